// File: rtl/window_3x3_gen_pkg.sv
// Shared definitions for the 3x3 window generator and the 3x3 filters fed by it.
package window_3x3_gen_pkg;

    localparam int WIN_ROWS       = 3;
    localparam int WIN_COLS       = 3;
    localparam int WIN_ELEMS      = WIN_ROWS * WIN_COLS;
    localparam int WIN_CENTRE     = 4;
    localparam int WIN_NEWEST_COL = 2;

    // Frame/line markers that travel alongside each window.
    typedef struct packed {
        logic sof;
        logic eof;
        logic sol;
        logic eol;
    } marker_t;

    // Flat element index of window row r (0 = oldest line), column c (0 = oldest column).
    function automatic int winIndex(input int row, input int col);
        return WIN_COLS * row + col;
    endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out stream bundle of the 3x3 window generator.
interface window_3x3_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      in_val;
    logic                      in_rdy;
    logic [DATA_WIDTH-1:0]     in_data;
    logic                      in_sof;
    logic                      in_eof;
    logic                      in_sol;
    logic                      in_eol;
    logic                      out3x3_val;
    logic                      out3x3_rdy;
    logic [9*DATA_WIDTH-1:0]   out3x3_data;
    logic                      out3x3_sof;
    logic                      out3x3_eof;
    logic                      out3x3_sol;
    logic                      out3x3_eol;

    modport slave (
        input  in_val, in_data, in_sof, in_eof, in_sol, in_eol, out3x3_rdy,
        output in_rdy, out3x3_val, out3x3_data, out3x3_sof, out3x3_eof, out3x3_sol, out3x3_eol
    );

    modport master (
        output in_val, in_data, in_sof, in_eof, in_sol, in_eol, out3x3_rdy,
        input  in_rdy, out3x3_val, out3x3_data, out3x3_sof, out3x3_eof, out3x3_sol, out3x3_eol
    );
endinterface

// File: rtl/window_3x3_gen_line_buf_ram.sv
// One line of pixel storage: single write port, asynchronous read at the same address.
module line_buf_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write the addressed entry; the read below still sees the old value this cycle.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Builds a sliding 3x3 pixel window from a raster stream using two line buffers.
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WIDTH  = 1024
) (
    input  logic            clk,
    input  logic            rst,
    window_3x3_gen_if.slave bus
);

    localparam int COL_W  = $clog2(MAX_WIDTH + 1);
    localparam int ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    logic                  r_armed;
    logic [1:0]            r_row;
    logic [COL_W-1:0]      r_col;
    logic [DATA_WIDTH-1:0] r_win [WIN_ELEMS];
    logic                  r_val;
    marker_t               r_mark;

    logic                  w_accept;
    logic                  w_armed;
    logic [1:0]            w_row;
    logic [COL_W-1:0]      w_col;
    logic                  w_inRange;
    logic                  w_write;
    logic                  w_complete;
    logic [ADDR_W-1:0]     w_addr;
    logic [COL_W-1:0]      w_colNext;
    logic [1:0]            w_rowNext;
    marker_t               w_mark;
    logic [DATA_WIDTH-1:0] w_l1Rd;
    logic [DATA_WIDTH-1:0] w_l2Rd;

    assign bus.in_rdy = ~r_val | bus.out3x3_rdy;

    // Position of the incoming pixel after sof/sol restarts, and what its acceptance does.
    always_comb begin
        w_accept   = bus.in_val & bus.in_rdy;
        w_armed    = r_armed | bus.in_sof;
        w_row      = bus.in_sof ? 2'd0 : r_row;
        w_col      = (bus.in_sof | bus.in_sol) ? '0 : r_col;
        w_inRange  = (w_col < COL_W'(MAX_WIDTH));
        w_write    = w_accept & w_armed & w_inRange;
        w_complete = w_write & (w_row >= 2'd2) & (w_col >= COL_W'(2));
        w_addr     = w_col[ADDR_W-1:0];
        w_colNext  = (w_col == COL_W'(MAX_WIDTH)) ? w_col : w_col + COL_W'(1);
        w_rowNext  = (bus.in_eol && (w_row != 2'd3)) ? w_row + 2'd1 : w_row;
        w_mark.sof = (w_row == 2'd2) && (w_col == COL_W'(2));
        w_mark.eof = bus.in_eof;
        w_mark.sol = (w_col == COL_W'(2));
        w_mark.eol = bus.in_eol;
    end

    // Row/column tracking; pixels before the first sof leave everything untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
            r_row   <= 2'd0;
            r_col   <= '0;
        end else if (w_accept && w_armed) begin
            r_armed <= 1'b1;
            r_row   <= w_rowNext;
            r_col   <= w_colNext;
        end
    end

    // L1 holds the previous line, L2 the line before; L1's old entry ages into L2.
    line_buf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_WIDTH),
        .ADDR_WIDTH (ADDR_W)
    ) u_lineBuf1 (
        .clk     (clk),
        .i_we    (w_write),
        .i_addr  (w_addr),
        .i_wdata (bus.in_data),
        .o_rdata (w_l1Rd)
    );

    line_buf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_WIDTH),
        .ADDR_WIDTH (ADDR_W)
    ) u_lineBuf2 (
        .clk     (clk),
        .i_we    (w_write),
        .i_addr  (w_addr),
        .i_wdata (w_l1Rd),
        .o_rdata (w_l2Rd)
    );

    // Slide the window one column left and bring in the new column oldest-line first.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < WIN_ELEMS; k++) begin
                r_win[k] <= '0;
            end
        end else if (w_write) begin
            for (int r = 0; r < WIN_ROWS; r++) begin
                for (int c = 0; c < WIN_NEWEST_COL; c++) begin
                    r_win[winIndex(r, c)] <= r_win[winIndex(r, c + 1)];
                end
            end
            r_win[winIndex(0, WIN_NEWEST_COL)] <= w_l2Rd;
            r_win[winIndex(1, WIN_NEWEST_COL)] <= w_l1Rd;
            r_win[winIndex(2, WIN_NEWEST_COL)] <= bus.in_data;
        end
    end

    // Output valid/markers: raised by a completed window, dropped once it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val  <= 1'b0;
            r_mark <= '0;
        end else if (w_complete) begin
            r_val  <= 1'b1;
            r_mark <= w_mark;
        end else if (r_val && bus.out3x3_rdy) begin
            r_val  <= 1'b0;
            r_mark <= '0;
        end
    end

    for (genvar k = 0; k < WIN_ELEMS; k++) begin : g_outData
        assign bus.out3x3_data[k*DATA_WIDTH +: DATA_WIDTH] = r_win[k];
    end

    assign bus.out3x3_val = r_val;
    assign bus.out3x3_sof = r_mark.sof;
    assign bus.out3x3_eof = r_mark.eof;
    assign bus.out3x3_sol = r_mark.sol;
    assign bus.out3x3_eol = r_mark.eol;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen: frame-level window model plus literal pins.
module tb_window_3x3_gen;
    import window_3x3_gen_pkg::*;

    localparam int DW   = 8;
    localparam int MAXW = 16;
    localparam int WW   = 9 * DW;

    typedef struct packed {
        logic [WW-1:0] data;
        logic [3:0]    mark;
    } win_t;

    logic clk = 1'b0;
    logic rst;

    window_3x3_gen_if #(.DATA_WIDTH(DW)) bus ();

    window_3x3_gen #(
        .DATA_WIDTH (DW),
        .MAX_WIDTH  (MAXW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    win_t expQ[$];
    win_t capQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   sofSeen     = 0;
    int   eofSeen     = 0;
    int   rdyMode     = 0;
    int   stallLeft   = 0;
    bit   stallUsed   = 0;
    bit   sawInRdyLow = 0;

    task automatic checkOutput(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready: always on, random, or one 5-cycle stall on the first window.
    initial begin
        bus.out3x3_rdy = 1'b1;
        forever begin
            @(negedge clk);
            case (rdyMode)
                0: bus.out3x3_rdy = 1'b1;
                1: bus.out3x3_rdy = ($urandom_range(0, 2) != 0);
                default: begin
                    if (bus.out3x3_val && !stallUsed) begin
                        stallUsed = 1'b1;
                        stallLeft = 5;
                    end
                    if (stallLeft > 0) begin
                        bus.out3x3_rdy = 1'b0;
                        stallLeft--;
                    end else begin
                        bus.out3x3_rdy = 1'b1;
                    end
                end
            endcase
        end
    end

    // Every cycle: ready rule, hold-while-stalled, and each handed-over window vs the model.
    initial begin
        win_t          got;
        win_t          exp;
        logic [WW-1:0] prevData = '0;
        logic [3:0]    prevMark = '0;
        bit            prevStall = 1'b0;
        logic [3:0]    mark;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prevStall = 1'b0;
                continue;
            end
            mark = {bus.out3x3_sof, bus.out3x3_eof, bus.out3x3_sol, bus.out3x3_eol};
            if (!bus.in_rdy) sawInRdyLow = 1'b1;
            checkOutput("in_rdy", WW'(bus.in_rdy), WW'(!bus.out3x3_val || bus.out3x3_rdy));
            if (prevStall) begin
                checkOutput("held_val", WW'(bus.out3x3_val), WW'(1));
                checkOutput("held_data", bus.out3x3_data, prevData);
                checkOutput("held_mark", WW'(mark), WW'(prevMark));
            end
            if (bus.out3x3_val && bus.out3x3_rdy) begin
                got.data = bus.out3x3_data;
                got.mark = mark;
                capQ.push_back(got);
                sofSeen += int'(mark[3]);
                eofSeen += int'(mark[2]);
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_window: got data %0h marks %b, expected no window", got.data, got.mark);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("win_data", got.data, exp.data);
                    checkOutput("win_mark", WW'(got.mark), WW'(exp.mark));
                end
            end
            prevStall = bus.out3x3_val && !bus.out3x3_rdy;
            prevData  = bus.out3x3_data;
            prevMark  = mark;
        end
    end

    task automatic drivePixel(input logic [DW-1:0] d, input logic sof, input logic eof,
                              input logic sol, input logic eol, input int gapPct);
        int  waited = 0;
        bit  done   = 1'b0;
        while (int'($urandom_range(0, 99)) < gapPct) begin
            @(negedge clk);
            bus.in_val = 1'b0;
        end
        @(negedge clk);
        bus.in_val  = 1'b1;
        bus.in_data = d;
        bus.in_sof  = sof;
        bus.in_eof  = eof;
        bus.in_sol  = sol;
        bus.in_eol  = eol;
        while (!done) begin
            #1;
            if (bus.in_rdy) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 1000) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL accept_timeout: pixel %0h not accepted, expected acceptance within 1000 cycles", d);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    // Drive the first nPix pixels of a w x h raster frame valued base+index; optionally queue its windows.
    task automatic applyStimulus(input int w, input int h, input int base, input bit withSof,
                                 input int gapPct, input int nPix, input bit expectWins);
        win_t e;
        if (expectWins) begin
            for (int r = 2; r < h; r++) begin
                for (int c = 2; c < w; c++) begin
                    for (int i = 0; i < 3; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            e.data[(3*i+j)*DW +: DW] = DW'(base + (r-2+i)*w + (c-2+j));
                        end
                    end
                    e.mark = {(r == 2 && c == 2), (r == h-1 && c == w-1), (c == 2), (c == w-1)};
                    expQ.push_back(e);
                end
            end
        end
        for (int idx = 0; idx < nPix; idx++) begin
            drivePixel(DW'(base + idx), withSof && idx == 0, (idx/w == h-1) && (idx%w == w-1),
                       (idx%w == 0), (idx%w == w-1), gapPct);
        end
        @(negedge clk);
        bus.in_val = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((expQ.size() != 0 || bus.out3x3_val) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL %s_drain: %0d windows outstanding, expected 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst        = 1'b1;
        bus.in_val = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("rst_val", WW'(bus.out3x3_val), WW'(0));
        checkOutput("rst_data", bus.out3x3_data, WW'(0));
        checkOutput("rst_mark", WW'({bus.out3x3_sof, bus.out3x3_eof, bus.out3x3_sol, bus.out3x3_eol}), WW'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int sofBase;
        int eofBase;
        rst         = 1'b1;
        bus.in_val  = 1'b0;
        bus.in_data = '0;
        bus.in_sof  = 1'b0;
        bus.in_eof  = 1'b0;
        bus.in_sol  = 1'b0;
        bus.in_eol  = 1'b0;
        repeat (3) @(negedge clk);
        doReset();

        base = capQ.size();
        applyStimulus(4, 3, 0, 1'b1, 0, 12, 1'b1);
        waitDrain("frame4x3");
        checkOutput("f4x3_count", WW'(capQ.size() - base), WW'(2));
        if (capQ.size() >= base + 2) begin
            checkOutput("f4x3_win0", capQ[base].data, 72'h0A0908060504020100);
            checkOutput("f4x3_mark0", WW'(capQ[base].mark), WW'(4'b1010));
            checkOutput("f4x3_win1", capQ[base+1].data, 72'h0B0A09070605030201);
            checkOutput("f4x3_mark1", WW'(capQ[base+1].mark), WW'(4'b0101));
        end

        rdyMode     = 2;
        stallUsed   = 1'b0;
        sawInRdyLow = 1'b0;
        base        = capQ.size();
        applyStimulus(4, 3, 0, 1'b1, 0, 12, 1'b1);
        waitDrain("stall");
        rdyMode = 0;
        checkOutput("stall_count", WW'(capQ.size() - base), WW'(2));
        checkOutput("stall_in_rdy_low", WW'(sawInRdyLow), WW'(1));
        if (capQ.size() >= base + 1) begin
            checkOutput("stall_win0", capQ[base].data, 72'h0A0908060504020100);
        end

        sawInRdyLow = 1'b0;
        base        = capQ.size();
        applyStimulus(2, 2, 50, 1'b1, 0, 4, 1'b1);
        waitDrain("frame2x2");
        checkOutput("f2x2_count", WW'(capQ.size() - base), WW'(0));
        checkOutput("f2x2_in_rdy_low", WW'(sawInRdyLow), WW'(0));

        applyStimulus(4, 3, 0, 1'b1, 0, 6, 1'b0);
        doReset();
        base = capQ.size();
        applyStimulus(4, 3, 100, 1'b1, 0, 12, 1'b1);
        waitDrain("midreset");
        checkOutput("midreset_count", WW'(capQ.size() - base), WW'(2));
        if (capQ.size() >= base + 1) begin
            checkOutput("midreset_centre", WW'(capQ[base].data[WIN_CENTRE*DW +: DW]), WW'(105));
        end

        doReset();
        base = capQ.size();
        applyStimulus(3, 3, 200, 1'b0, 0, 9, 1'b0);
        applyStimulus(3, 3, 0, 1'b1, 0, 9, 1'b1);
        waitDrain("nosof");
        checkOutput("nosof_count", WW'(capQ.size() - base), WW'(1));
        if (capQ.size() >= base + 1) begin
            checkOutput("f3x3_centre", WW'(capQ[base].data[WIN_CENTRE*DW +: DW]), WW'(4));
            checkOutput("f3x3_mark", WW'(capQ[base].mark), WW'(4'b1111));
        end

        rdyMode = 1;
        sofBase = sofSeen;
        eofBase = eofSeen;
        base    = capQ.size();
        applyStimulus(16, 8, 0, 1'b1, 30, 128, 1'b1);
        waitDrain("random16x8");
        rdyMode = 0;
        checkOutput("rand_count", WW'(capQ.size() - base), WW'(84));
        checkOutput("rand_sof", WW'(sofSeen - sofBase), WW'(1));
        checkOutput("rand_eof", WW'(eofSeen - eofBase), WW'(1));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
